// File: rtl/avg_pool_stream.sv
// Streaming 2x2 / stride-2 average pooling over one raster-order feature map.
// Optional build macro POOL_ROUND_EN: round half toward +inf instead of floor.
module avg_pool_stream #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MAX_W  = 32,
  parameter int unsigned SIZE_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SIZE_W-1:0]        map_size,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     finish
);

  localparam int unsigned LB_DEPTH = (MAX_W / 2 > 0) ? MAX_W / 2 : 1;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int unsigned PAIR_W   = DATA_W + 1;
  localparam int unsigned SUM_W    = DATA_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                     r_state;
  logic [SIZE_W-1:0]          r_size;
  logic                       r_size_ok;
  logic [SIZE_W-1:0]          r_row;
  logic [SIZE_W-1:0]          r_col;
  logic signed [DATA_W-1:0]   r_prev;
  logic signed [PAIR_W-1:0]   r_line_buf [LB_DEPTH];

  logic                       w_accept;
  logic                       w_last_col;
  logic                       w_last_row;
  logic                       w_pair_wr;
  logic                       w_pool_out;
  logic [LB_AW-1:0]           w_lb_idx;
  logic signed [PAIR_W-1:0]   w_pair;
  logic signed [SUM_W-1:0]    w_sum;
  logic signed [SUM_W-1:0]    w_sum_rnd;
  logic signed [DATA_W-1:0]   w_pooled;

  // Input stalls only while a pooled result is blocked downstream.
  assign in_ready   = (r_state == S_RUN) && !(out_valid && !out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_last_col = (r_col == r_size - SIZE_W'(1));
  assign w_last_row = (r_row == r_size - SIZE_W'(1));
  assign w_lb_idx   = LB_AW'(r_col >> 1);
  assign w_pair_wr  = w_accept && r_size_ok && !r_row[0] && r_col[0];
  assign w_pool_out = w_accept && r_size_ok && r_row[0] && r_col[0];

  assign w_pair = {r_prev[DATA_W-1], r_prev} + {in_data[DATA_W-1], in_data};
  assign w_sum  = {r_line_buf[w_lb_idx][PAIR_W-1], r_line_buf[w_lb_idx]}
                + {{2{r_prev[DATA_W-1]}}, r_prev}
                + {{2{in_data[DATA_W-1]}}, in_data};

`ifdef POOL_ROUND_EN
  assign w_sum_rnd = w_sum + SUM_W'(2);
`else
  assign w_sum_rnd = w_sum;
`endif

  // Four-pixel sum of full-scale inputs stays inside SUM_W, so /4 fits DATA_W.
  assign w_pooled = DATA_W'(w_sum_rnd >>> 2);

  // Horizontal pair sums of even rows, consumed by the following odd row.
  always_ff @(posedge clk) begin
    if (w_pair_wr) begin
      r_line_buf[w_lb_idx] <= w_pair;
    end
  end

  // Control FSM, raster counters and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_size    <= '0;
      r_size_ok <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
      r_prev    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      finish    <= 1'b0;
    end else begin
      finish <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_size    <= map_size;
            r_size_ok <= (map_size >= SIZE_W'(2)) && (32'(map_size) <= MAX_W);
            r_row     <= '0;
            r_col     <= '0;
            busy      <= 1'b1;
            // An empty map has nothing to consume.
            r_state   <= (map_size == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_prev <= in_data;
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + SIZE_W'(1);
              if (w_last_row) begin
                r_state <= S_DRAIN;
              end
            end else begin
              r_col <= r_col + SIZE_W'(1);
            end
            if (w_pool_out) begin
              out_data  <= w_pooled;
              out_valid <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!out_valid || out_ready) begin
            r_state <= S_DONE;
            finish  <= 1'b1;
            busy    <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avg_pool_stream.sv
// Directed, table-driven bench for avg_pool_stream (floor or POOL_ROUND_EN build).
module tb_avg_pool_stream;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned MAX_W  = 32;
  localparam int unsigned SIZE_W = 6;

`ifdef POOL_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [SIZE_W-1:0]        map_size;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_ready = 1'b1;
  logic                     busy;
  logic                     finish;

  always #5 clk = ~clk;

  avg_pool_stream #(.DATA_W(DATA_W), .MAX_W(MAX_W), .SIZE_W(SIZE_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .map_size (map_size),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy),
    .finish   (finish)
  );

  // kind: 0 ramp (value = raster index), 1 constant cval, 2 -(index+1)
  // mode: 0 out_ready=1, 1 stall 5 cycles at first output, 2 random gaps
  typedef struct {
    int size;
    int kind;
    int cval;
    int mode;
    int poke;
    int n_exp;
    int e0;
    int e1;
    int e2;
    int e3;
  } vec_t;

  vec_t vecs[9];

  int n_checks = 0;
  int n_errs   = 0;
  int got[$];
  int acc_cnt = 0;
  int fin_cnt = 0;
  int cyc = 0;
  int last_out_cyc = 0;
  int fin_cyc = 0;
  bit rand_ready = 1'b0;
  bit stall_arm = 1'b0;
  int stall_left = 0;
  bit hold_pend = 1'b0;
  int hold_data = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_at(input vec_t v, input int i);
    case (i)
      0:       return v.e0;
      1:       return v.e1;
      2:       return v.e2;
      3:       return v.e3;
      default: return v.e0;
    endcase
  endfunction

  function automatic int pix_val(input vec_t v, input int idx);
    case (v.kind)
      0:       return idx;
      1:       return v.cval;
      default: return -(idx + 1);
    endcase
  endfunction

  // Drive out_ready before each edge, then sample transfers and handshake rules.
  always @(negedge clk) begin
    if (stall_arm && out_valid) begin
      stall_left = 5;
      stall_arm  = 1'b0;
    end
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (rand_ready) begin
      out_ready = ($urandom_range(0, 2) != 0);
    end else begin
      out_ready = 1'b1;
    end
    #1;
    cyc++;
    if (hold_pend) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'(out_data), hold_data);
    end
    hold_pend = out_valid && !out_ready && !rst;
    hold_data = int'(out_data);
    if (hold_pend) chk("in_ready_blocked", int'(in_ready), 0);
    if (out_valid && out_ready) begin
      got.push_back(int'(out_data));
      last_out_cyc = cyc;
    end
    if (in_valid && in_ready) acc_cnt++;
    if (finish) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
  end

  task automatic start_map(input int size);
    @(posedge clk); #1;
    map_size = SIZE_W'(size);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic feed(input vec_t v, input int count);
    bit acc;
    int guard;
    for (int idx = 0; idx < count; idx++) begin
      if (v.mode == 2) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = DATA_W'(pix_val(v, idx));
      if (v.poke != 0 && idx == 3) begin
        start    = 1'b1;
        map_size = SIZE_W'(2);
      end
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 1000) begin
        @(negedge clk); #1;
        acc = in_ready;
        @(posedge clk); #1;
        guard++;
      end
      start = 1'b0;
      if (!acc) begin
        chk("in_accept_timeout", idx, -1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_map(input vec_t v);
    int g;
    int n;
    got.delete();
    acc_cnt    = 0;
    fin_cnt    = 0;
    rand_ready = (v.mode == 2);
    stall_arm  = (v.mode == 1);
    chk("busy_before", int'(busy), 0);
    start_map(v.size);
    chk("busy_after_start", int'(busy), 1);
    feed(v, v.size * v.size);
    g = 0;
    while (fin_cnt == 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    #1;
    repeat (3) @(posedge clk);
    #1;
    chk("finish_count", fin_cnt, 1);
    chk("busy_end", int'(busy), 0);
    chk("in_count", acc_cnt, v.size * v.size);
    chk("out_count", got.size(), v.n_exp);
    n = (got.size() < v.n_exp) ? got.size() : v.n_exp;
    for (int i = 0; i < n; i++) chk("out_value", got[i], exp_at(v, i));
    if (v.mode == 0 && v.n_exp > 0 && (v.size % 2) == 0)
      chk("finish_latency", int'((fin_cyc - last_out_cyc) >= 1 && (fin_cyc - last_out_cyc) <= 2), 1);
    rand_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4, 0, 0, 0, 0, 4, RND ? 3 : 2, RND ? 5 : 4, RND ? 11 : 10, RND ? 13 : 12};
    vecs[1] = '{2, 2, 0, 0, 0, 1, RND ? -2 : -3, 0, 0, 0};
    vecs[2] = '{4, 0, 0, 1, 0, 4, RND ? 3 : 2, RND ? 5 : 4, RND ? 11 : 10, RND ? 13 : 12};
    vecs[3] = '{5, 0, 0, 0, 0, 4, 3, 5, 13, 15};
    vecs[4] = '{28, 1, 32767, 2, 0, 196, 32767, 32767, 32767, 32767};
    vecs[5] = '{10, 1, -32768, 2, 0, 25, -32768, -32768, -32768, -32768};
    vecs[6] = '{1, 1, 7, 0, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{34, 1, 100, 0, 0, 0, 0, 0, 0, 0};
    vecs[8] = '{4, 0, 0, 0, 1, 4, RND ? 3 : 2, RND ? 5 : 4, RND ? 11 : 10, RND ? 13 : 12};

    rst      = 1'b1;
    start    = 1'b0;
    map_size = '0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_finish", int'(finish), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_map(vecs[i]);

    // Abort a 4x4 map after seven pixels with a synchronous reset.
    got.delete();
    fin_cnt = 0;
    start_map(4);
    feed(vecs[0], 7);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_finish", fin_cnt, 0);
    run_map(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
